// File: rtl/tdm_demux_1x4_pkg.sv
// Shared types for the 4-slot TDM receive demux.
// Slot index, slot count and the two-state framer encoding.
package tdm_demux_1x4_pkg;

    localparam int NUM_SLOTS = 4;

    typedef logic [1:0] slot_t;

    typedef enum logic {
        HUNT  = 1'b0,
        TRACK = 1'b1
    } state_t;

endpackage

// File: rtl/tdm_demux_1x4_cell.sv
// 1-to-2 demux cell: routes d to y0 when s is low, to y1 when s is high.
// Purely combinational, no backpressure.
module demux_1x2_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] d,
    input  logic             s,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1
);

    assign y0 = d & {WIDTH{~s}};
    assign y1 = d & {WIDTH{s}};

endmodule

// File: rtl/tdm_demux_1x4.sv
// Splits a 4-slot rotating TDM lane back into four channels, released together per frame.
// Latency: 1 clock from the slot-3 beat to y0..y3 and frame_valid; no backpressure, beats accepted whenever din_valid.
module tdm_demux_1x4 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    import tdm_demux_1x4_pkg::*;

    state_t           state_q, state_d;
    slot_t            cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow0_q, shadow0_d;
    logic [WIDTH-1:0] shadow1_q, shadow1_d;
    logic [WIDTH-1:0] shadow2_q, shadow2_d;
    logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    logic             wr_en;
    logic             misalign;
    slot_t            sel;
    logic [WIDTH:0]   lane;
    logic [WIDTH:0]   lvl1_even, lvl1_odd;
    logic [WIDTH:0]   slot0, slot1, slot2, slot3;

    // A sync beat always lands in slot 0, whatever the counter says.
    assign wr_en    = din_valid && ((state_q == TRACK) || sync);
    assign misalign = din_valid && sync && (state_q == TRACK) && (cnt_q != 2'd0);
    assign sel      = sync ? 2'd0 : cnt_q;

    // Write strobe rides in the MSB so the tree yields strobe and data per slot.
    assign lane = {wr_en, din};

    demux_1x2_cell #(.WIDTH(WIDTH + 1)) u_lvl1 (
        .d  (lane),
        .s  (sel[0]),
        .y0 (lvl1_even),
        .y1 (lvl1_odd)
    );

    demux_1x2_cell #(.WIDTH(WIDTH + 1)) u_lvl2_even (
        .d  (lvl1_even),
        .s  (sel[1]),
        .y0 (slot0),
        .y1 (slot2)
    );

    demux_1x2_cell #(.WIDTH(WIDTH + 1)) u_lvl2_odd (
        .d  (lvl1_odd),
        .s  (sel[1]),
        .y0 (slot1),
        .y1 (slot3)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow0_d     = shadow0_q;
        shadow1_d     = shadow1_q;
        shadow2_d     = shadow2_q;
        y0_d          = y0_q;
        y1_d          = y1_q;
        y2_d          = y2_q;
        y3_d          = y3_q;
        frame_valid_d = 1'b0;
        sync_err_d    = misalign;

        if (wr_en) begin
            state_d = TRACK;
            cnt_d   = sel + 2'd1;
        end

        if (slot0[WIDTH]) shadow0_d = slot0[WIDTH-1:0];
        if (slot1[WIDTH]) shadow1_d = slot1[WIDTH-1:0];
        if (slot2[WIDTH]) shadow2_d = slot2[WIDTH-1:0];

        // Slot 3 completes the frame; it bypasses the shadow and goes straight out.
        if (slot3[WIDTH]) begin
            y0_d          = shadow0_q;
            y1_d          = shadow1_q;
            y2_d          = shadow2_q;
            y3_d          = slot3[WIDTH-1:0];
            frame_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HUNT;
            cnt_q         <= '0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            y0_q          <= '0;
            y1_q          <= '0;
            y2_q          <= '0;
            y3_q          <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow0_q     <= shadow0_d;
            shadow1_q     <= shadow1_d;
            shadow2_q     <= shadow2_d;
            y0_q          <= y0_d;
            y1_q          <= y1_d;
            y2_q          <= y2_d;
            y3_q          <= y3_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == TRACK);

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// Bench for tdm_demux_1x4 (WIDTH=4): directed vector table, reset sequences, random traffic vs. a frame model.
module tb_tdm_demux_1x4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         sync = 1'b0;
    logic [W-1:0] y0, y1, y2, y3;
    logic         frame_valid, locked, sync_err;

    int errors = 0;
    int checks = 0;

    tdm_demux_1x4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .sync        (sync),
        .y0          (y0),
        .y1          (y1),
        .y2          (y2),
        .y3          (y3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic         s;
        logic [W-1:0] d;
        logic         fv;
        logic         er;
        logic         lk;
        logic [15:0]  y;   // {y0,y1,y2,y3}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic s, input logic [W-1:0] d,
                                input logic fv, input logic er, input logic lk,
                                input logic [15:0] y);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.fv = fv; r.er = er; r.lk = lk; r.y = y;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic fv, input logic er,
                           input logic lk, input logic [15:0] y);
        chk({tag, " frame_valid"}, 32'(frame_valid), 32'(fv));
        chk({tag, " sync_err"},    32'(sync_err),    32'(er));
        chk({tag, " locked"},      32'(locked),      32'(lk));
        chk({tag, " y"},           32'({y0, y1, y2, y3}), 32'(y));
    endtask

    task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
        din_valid = v;
        sync      = s;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        din_valid = 1'b0;
        sync      = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reference: frame assembly by slot position, released whole on slot 3.
    logic [W-1:0] m_buf[4];
    logic [W-1:0] m_out[4];
    int           m_pos;
    bit           m_lock;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_buf[i] = '0;
            m_out[i] = '0;
        end
        m_pos  = 0;
        m_lock = 0;
    endtask

    initial begin
        // Directed frames, applied back to back from reset.
        tbl.push_back(mk(1, 1, 4'hA, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 4'hB, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 4'hC, 0, 0, 1, 16'h0000));
        tbl.push_back(mk(1, 0, 4'hD, 1, 0, 1, 16'hABCD));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'hABCD));
        // Frame without sync, gaps of three idle cycles; old frame held.
        tbl.push_back(mk(1, 0, 4'h9, 0, 0, 1, 16'hABCD));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'hABCD));
        tbl.push_back(mk(1, 0, 4'h8, 0, 0, 1, 16'hABCD));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'hABCD));
        tbl.push_back(mk(1, 0, 4'h7, 0, 0, 1, 16'hABCD));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'hABCD));
        tbl.push_back(mk(1, 0, 4'h6, 1, 0, 1, 16'h9876));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'h9876));
        // Partial frame 1,2 broken by a sync: error pulse, then clean frame.
        tbl.push_back(mk(1, 0, 4'h1, 0, 0, 1, 16'h9876));
        tbl.push_back(mk(1, 0, 4'h2, 0, 0, 1, 16'h9876));
        tbl.push_back(mk(1, 1, 4'hA, 0, 1, 1, 16'h9876));
        tbl.push_back(mk(1, 0, 4'hB, 0, 0, 1, 16'h9876));
        tbl.push_back(mk(1, 0, 4'hC, 0, 0, 1, 16'h9876));
        tbl.push_back(mk(1, 0, 4'hD, 1, 0, 1, 16'hABCD));
        // Eight continuous beats, sync on 0 and 4: pulses four cycles apart.
        tbl.push_back(mk(1, 1, 4'h1, 0, 0, 1, 16'hABCD));
        tbl.push_back(mk(1, 0, 4'h2, 0, 0, 1, 16'hABCD));
        tbl.push_back(mk(1, 0, 4'h3, 0, 0, 1, 16'hABCD));
        tbl.push_back(mk(1, 0, 4'h4, 1, 0, 1, 16'h1234));
        tbl.push_back(mk(1, 1, 4'h5, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(1, 0, 4'h6, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(1, 0, 4'h7, 0, 0, 1, 16'h1234));
        tbl.push_back(mk(1, 0, 4'h8, 1, 0, 1, 16'h5678));
        tbl.push_back(mk(0, 0, 4'h0, 0, 0, 1, 16'h5678));

        // Reset state.
        @(posedge clk);
        #1;
        chk_out("reset", 0, 0, 0, 16'h0000);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            beat(tbl[i].v, tbl[i].s, tbl[i].d);
            chk_out($sformatf("vec%0d", i), tbl[i].fv, tbl[i].er, tbl[i].lk, tbl[i].y);
        end

        // Beats without sync in HUNT are dropped.
        do_reset();
        beat(1, 0, 4'h5);
        chk_out("hunt5", 0, 0, 0, 16'h0000);
        beat(1, 0, 4'h6);
        chk_out("hunt6", 0, 0, 0, 16'h0000);
        beat(1, 1, 4'h1);
        beat(1, 0, 4'h2);
        beat(1, 0, 4'h3);
        beat(1, 0, 4'h4);
        chk_out("hunt_frame", 1, 0, 1, 16'h1234);

        // Asynchronous reset in the middle of a frame.
        beat(1, 1, 4'h5);
        beat(1, 0, 4'h6);
        beat(1, 0, 4'h7);
        rst = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        beat(1, 0, 4'h4);
        chk_out("post_rst4", 0, 0, 0, 16'h0000);

        // Random traffic against the frame model.
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            logic         v, s, efv, eer;
            logic [W-1:0] d;
            v   = ($urandom_range(0, 9) < 7);
            s   = ($urandom_range(0, 9) < 2);
            d   = W'($urandom);
            efv = 0;
            eer = 0;
            if (v) begin
                if (!m_lock) begin
                    if (s) begin
                        m_lock   = 1;
                        m_buf[0] = d;
                        m_pos    = 1;
                    end
                end else if (s && m_pos != 0) begin
                    eer      = 1;
                    m_buf[0] = d;
                    m_pos    = 1;
                end else begin
                    m_buf[m_pos] = d;
                    if (m_pos == 3) begin
                        for (int k = 0; k < 4; k++) m_out[k] = m_buf[k];
                        efv = 1;
                    end
                    m_pos = (m_pos + 1) % 4;
                end
            end
            beat(v, s, d);
            chk_out($sformatf("rnd%0d", c), efv, eer, m_lock,
                    {m_out[0], m_out[1], m_out[2], m_out[3]});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive side of the team's 4:1 select-multiplexed link: one shared data lane carries four slots in rotation (slot 0..3), and this block routes each beat back to its own output channel.
- The routing core is a 1-to-2 demux cell cascaded as a 1-to-4 tree, steered by an internal slot counter.
- Captured beats are double-buffered, so all four channel outputs update together once per complete frame.
- Sits directly after the link input and feeds the per-channel consumers.

Parameters:
- WIDTH, 1: bits per slot, applies to the data lane and to each channel output.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  WIDTH  shared data lane.
- din_valid  input  1  din carries a slot beat this cycle.
- sync  input  1  qualified by din_valid; marks the current beat as slot 0.
- y0  output  WIDTH  channel 0, held between frames.
- y1  output  WIDTH  channel 1, held between frames.
- y2  output  WIDTH  channel 2, held between frames.
- y3  output  WIDTH  channel 3, held between frames.
- frame_valid  output  1  one-cycle pulse; y0..y3 were just updated.
- locked  output  1  high while tracking frames.
- sync_err  output  1  one-cycle pulse; sync was seen at a slot other than 0.

Behaviour:
- Reset (asynchronous, active-high): y0..y3 = 0, frame_valid = 0, sync_err = 0, locked = 0, slot counter = 0, shadow registers = 0, state = HUNT.
- States:
  - HUNT: beats without sync are ignored. On din_valid && sync, capture din into shadow[0], set counter = 1, go to TRACK, set locked = 1 on the same edge.
  - TRACK, din_valid && !sync: capture din into shadow[cnt] through the 1:4 demux tree. cnt[0] steers the first level, cnt[1] the second. cnt increments mod 4.
  - TRACK, din_valid && sync && cnt == 0: normal frame start; treat as an ordinary slot-0 capture.
  - TRACK, din_valid && sync && cnt != 0: misalignment.
    - Discard the partial frame.
    - Capture din as slot 0 and set cnt = 1.
    - Pulse sync_err for one cycle.
    - Do not pulse frame_valid; y0..y3 are unchanged; stay in TRACK.
  - TRACK, din_valid low: hold everything; gaps of any length are allowed between beats.
- sync is optional while locked. A slot-0 beat without sync is accepted through counter wrap.
- Frame completion: on the edge that captures slot 3 (cnt == 3, din_valid, no misaligned sync):
  - y0..y2 load from shadow; y3 loads directly from din.
  - frame_valid is high in the following cycle only.
  - Latency is 1 clock from the slot-3 beat to both the outputs and frame_valid.
- Outputs are registered and hold their values until the next complete frame.
- Reset asserted mid-frame: the partial frame is lost, all outputs clear immediately (asynchronous), state returns to HUNT.
- frame_valid and sync_err are never high in the same cycle.
- No arithmetic beyond the 2-bit wrapping counter.

Decomposition:
- Shared package holds the slot index typedef (2-bit), the NUM_SLOTS = 4 constant, and the state encoding constants HUNT = 1'b0, TRACK = 1'b1.
- One natural sub-module: demux_1x2_cell (inputs d, s; outputs y0 = d & ~s, y1 = d & s, bitwise for WIDTH). Instantiate it three times as the 1:4 tree that generates the shadow write strobes and data.

Test Plan:
- WIDTH=4, after reset, beats A,B,C,D with sync on A -> one cycle after D: y0..y3 = A,B,C,D, frame_valid = 1 for exactly 1 cycle, locked = 1.
- Beats 5,6 without sync while in HUNT, then sync+1,2,3,4 -> y0..y3 = 1,2,3,4; the 5 and 6 beats are never observed on any output.
- Locked; second frame 9,8,7,6 with no sync and 3 idle cycles between beats -> y = 9,8,7,6, frame_valid pulse only after the beat 6; the previous frame's values are held throughout.
- Locked; beats 1,2 then sync+A,B,C,D -> sync_err pulse on the cycle after A, no frame_valid for the 1,2 partial frame, then y = A,B,C,D with frame_valid.
- rst asserted after beats 1,2,3 of a frame (previous outputs nonzero) -> y0..y3 = 0, locked = 0 immediately. A following beat 4 without sync produces no frame_valid.
- Back-to-back frames with din_valid held high for 8 cycles, sync on cycles 0 and 4 -> two frame_valid pulses, exactly 4 cycles apart, and no sync_err.
